// File: rtl/eth_csr_av_master_if.sv
// Avalon-MM bus between the Ethernet CSR command responder and the MAC/PHY CSR fabric.
// Ports: avm_address/read/write/writedata (master out), avm_readdata/readdatavalid/waitrequest (slave out).
interface eth_csr_av_master_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;
  logic              avm_waitrequest;

  modport master (
    output avm_address,
    output avm_read,
    output avm_write,
    output avm_writedata,
    input  avm_readdata,
    input  avm_readdatavalid,
    input  avm_waitrequest
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    input  avm_write,
    input  avm_writedata,
    output avm_readdata,
    output avm_readdatavalid,
    output avm_waitrequest
  );
endinterface

// File: rtl/eth_csr_av_master.sv
// Ethernet CSR command responder: one Avalon-MM transaction per strobed control word.
// Ports: clk, reset_n (async low), eth_ctrl_addr/eth_wr_data in, eth_rd_data/csr_status out,
//        avm (Avalon master modport). Optional abort timer: define ETH_CSR_TIMEOUT_EN.
module eth_csr_av_master #(
  parameter int ADDR_W      = 16,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] eth_ctrl_addr,
  input  logic [31:0] eth_wr_data,
  output logic [31:0] eth_rd_data,
  output logic [2:0]  csr_status,
  eth_csr_av_master_if.master avm
);

  typedef enum logic [1:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    RD_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              to_q, to_d;
  logic              drop_q, drop_d;
  logic              accept;
  logic              expire;

  logic wr_stb;
  logic rd_stb;
  logic unused_bits;

  assign wr_stb = eth_ctrl_addr[16];
  assign rd_stb = eth_ctrl_addr[17];
  assign unused_bits = ^{eth_ctrl_addr, TIMEOUT_CYC[0]};

`ifdef ETH_CSR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] cnt_q;

  // Counter never passes TIMEOUT_CYC-1 while busy: that value aborts.
  assign expire = (state_q != IDLE) &&
                  (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= '0;
    end else if (state_q != IDLE) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end
`else
  assign expire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    to_d    = to_q;
    drop_d  = drop_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (wr_stb && rd_stb) begin
          drop_d = 1'b1;
        end else if (wr_stb) begin
          accept  = 1'b1;
          addr_d  = eth_ctrl_addr[ADDR_W-1:0];
          wdata_d = eth_wr_data;
          to_d    = 1'b0;
          drop_d  = 1'b0;
          wr_d    = 1'b1;
          state_d = WR_REQ;
        end else if (rd_stb) begin
          accept  = 1'b1;
          addr_d  = eth_ctrl_addr[ADDR_W-1:0];
          to_d    = 1'b0;
          drop_d  = 1'b0;
          rd_d    = 1'b1;
          state_d = RD_REQ;
        end
      end
      WR_REQ: begin
        if (!avm.avm_waitrequest) begin
          state_d = IDLE;
        end else if (expire) begin
          to_d    = 1'b1;
          state_d = IDLE;
        end else begin
          wr_d = 1'b1;
        end
      end
      RD_REQ: begin
        // Data arriving with the accept cycle finishes the read here.
        if (!avm.avm_waitrequest && avm.avm_readdatavalid) begin
          rdata_d = avm.avm_readdata;
          state_d = IDLE;
        end else if (expire) begin
          to_d    = 1'b1;
          rdata_d = '1;
          state_d = IDLE;
        end else if (!avm.avm_waitrequest) begin
          state_d = RD_WAIT;
        end else begin
          rd_d = 1'b1;
        end
      end
      RD_WAIT: begin
        if (avm.avm_readdatavalid) begin
          rdata_d = avm.avm_readdata;
          state_d = IDLE;
        end else if (expire) begin
          to_d    = 1'b1;
          rdata_d = '1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if ((state_q != IDLE) && (wr_stb || rd_stb)) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      to_q    <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      to_q    <= to_d;
      drop_q  <= drop_d;
    end
  end

  assign avm.avm_address   = addr_q;
  assign avm.avm_writedata = wdata_q;
  assign avm.avm_read      = rd_q;
  assign avm.avm_write     = wr_q;
  assign eth_rd_data       = rdata_q;
  assign csr_status        = {drop_q, to_q, state_q != IDLE};

endmodule

// File: tb/tb_eth_csr_av_master.sv
// Scoreboard bench for eth_csr_av_master with a randomised Avalon slave.
// Expected requests/completions are queued at issue time and checked by a negedge monitor.
module tb_eth_csr_av_master;
  localparam int AW = 16;
  localparam int TO = 8;
`ifdef ETH_CSR_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] eth_ctrl_addr = '0;
  logic [31:0] eth_wr_data = '0;
  logic [31:0] eth_rd_data;
  logic [2:0]  csr_status;

  eth_csr_av_master_if #(.ADDR_W(AW)) avm ();

  eth_csr_av_master #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .eth_ctrl_addr(eth_ctrl_addr),
    .eth_wr_data(eth_wr_data),
    .eth_rd_data(eth_rd_data),
    .csr_status(csr_status),
    .avm(avm)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    logic [AW-1:0] addr;
    logic [31:0] data;
    int          len;
  } req_t;

  typedef struct {
    logic [31:0] rd;
    logic [2:0]  st;
    int          busy_len;
  } cpl_t;

  req_t req_q[$];
  cpl_t cpl_q[$];
  int n_cmp = 0;
  int n_err = 0;

  // Software-visible state as the model sees it.
  logic [31:0] m_rd = '0;
  bit m_to = 1'b0;
  bit m_dr = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor
  logic in_req = 1'b0;
  logic busy_prev = 1'b0;
  logic act_m;
  req_t cur;
  cpl_t cc;
  int req_len = 0;
  int busy_len = 0;

  always @(negedge clk) begin
    act_m = avm.avm_read | avm.avm_write;
    if (avm.avm_read && avm.avm_write) chk("rd_wr_both", 1, 0);
    if (act_m && !in_req) begin
      if (req_q.size() == 0) begin
        chk("unexpected_req", 1, 0);
        cur = '{is_wr: avm.avm_write, addr: avm.avm_address,
                data: avm.avm_writedata, len: -1};
      end else begin
        cur = req_q.pop_front();
      end
      in_req = 1'b1;
      req_len = 0;
    end
    if (act_m && in_req) begin
      req_len++;
      chk("req_write", avm.avm_write, cur.is_wr);
      chk("req_addr", avm.avm_address, cur.addr);
      if (cur.is_wr) chk("req_wdata", avm.avm_writedata, cur.data);
    end
    if (!act_m && in_req) begin
      chk("req_len", req_len, cur.len);
      in_req = 1'b0;
    end
    if (csr_status[0]) busy_len++;
    if (busy_prev && !csr_status[0]) begin
      if (cpl_q.size() == 0) begin
        chk("unexpected_cpl", 1, 0);
      end else begin
        cc = cpl_q.pop_front();
        chk("rd_data", eth_rd_data, cc.rd);
        chk("status", csr_status, cc.st);
        chk("busy_len", busy_len, cc.busy_len);
      end
      busy_len = 0;
    end
    busy_prev = csr_status[0];
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One command: s = waitrequest-high cycles, d = cycles from accept to readdatavalid.
  task automatic run_txn(input bit is_wr, input logic [AW-1:0] addr,
                         input logic [31:0] wd, input logic [31:0] rdat,
                         input int s, input int d, input bit stray);
    int done_k, end_k, rlen, stray_k;
    bit tmo;
    done_k = is_wr ? s + 1 : s + 1 + d;
    tmo = TO_EN && (done_k > TO);
    end_k = tmo ? TO : done_k;
    rlen = (TO_EN && (s + 1 > TO)) ? TO : s + 1;
    stray_k = stray ? $urandom_range(end_k, 1) : 0;
    m_to = tmo;
    m_dr = (stray_k != 0);
    if (!is_wr) m_rd = tmo ? 32'hFFFF_FFFF : rdat;
    req_q.push_back('{is_wr: is_wr, addr: addr, data: wd, len: rlen});
    cpl_q.push_back('{rd: m_rd, st: {m_dr, m_to, 1'b0}, busy_len: end_k});
    eth_ctrl_addr = {14'($urandom), ~is_wr, is_wr, addr};
    eth_wr_data = wd;
    cyc();
    eth_ctrl_addr = '0;
    eth_wr_data = $urandom;
    for (int k = 1; k <= end_k; k++) begin
      avm.avm_waitrequest = (k <= s);
      if (is_wr) begin
        avm.avm_readdatavalid = 1'($urandom);
        avm.avm_readdata = $urandom;
      end else begin
        avm.avm_readdatavalid = (k == s + 1 + d);
        avm.avm_readdata = (k == s + 1 + d) ? rdat : $urandom;
      end
      if (k == stray_k)
        eth_ctrl_addr = {14'($urandom), 2'($urandom_range(3, 1)), 16'($urandom)};
      else
        eth_ctrl_addr = '0;
      cyc();
    end
    avm.avm_waitrequest = 1'b0;
    avm.avm_readdatavalid = 1'b0;
    eth_ctrl_addr = '0;
  endtask

  task automatic both_strobes(input logic [15:0] addr);
    eth_ctrl_addr = {14'h0, 2'b11, addr};
    cyc();
    eth_ctrl_addr = '0;
    m_dr = 1'b1;
    cyc();
    cyc();
    chk("both_status", csr_status, {m_dr, m_to, 1'b0});
    chk("both_rd_data", eth_rd_data, m_rd);
  endtask

  task automatic reset_mid_read();
    req_q.push_back('{is_wr: 1'b0, addr: 16'h0077, data: '0, len: 1});
    cpl_q.push_back('{rd: 32'h0, st: 3'b000, busy_len: 1});
    eth_ctrl_addr = 32'h0002_0077;
    cyc();
    eth_ctrl_addr = '0;
    avm.avm_waitrequest = 1'b0;
    cyc();
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_avm_read", avm.avm_read, 0);
    chk("rst_avm_write", avm.avm_write, 0);
    chk("rst_rd_data", eth_rd_data, 0);
    chk("rst_status", csr_status, 0);
    m_rd = '0;
    m_to = 1'b0;
    m_dr = 1'b0;
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not end, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    avm.avm_waitrequest = 1'b0;
    avm.avm_readdatavalid = 1'b0;
    avm.avm_readdata = '0;
    #1;
    chk("reset_read", avm.avm_read, 0);
    chk("reset_write", avm.avm_write, 0);
    chk("reset_addr", avm.avm_address, 0);
    chk("reset_wdata", avm.avm_writedata, 0);
    chk("reset_rd_data", eth_rd_data, 0);
    chk("reset_status", csr_status, 0);
    cyc();
    cyc();
    reset_n = 1'b1;
    cyc();

    run_txn(1'b1, 16'h0040, 32'hA5A5_0001, 32'h0, 0, 0, 1'b0);
    run_txn(1'b0, 16'h0010, 32'h0, 32'h1234_5678, 3, 2, 1'b0);
    run_txn(1'b0, 16'h0011, 32'h0, 32'hDEAD_BEEF, 20, 0, 1'b0);
    run_txn(1'b1, 16'h0042, 32'h0BAD_F00D, 32'h0, 1, 0, 1'b0);
    run_txn(1'b0, 16'h0020, 32'h0, 32'hCAFE_F00D, 1, 2, 1'b1);
    both_strobes(16'h0000);
    run_txn(1'b0, 16'h0021, 32'h0, 32'h5555_AAAA, 0, 0, 1'b0);
    reset_mid_read();
    run_txn(1'b0, 16'h0030, 32'h0, 32'h0F0F_0F0F, 0, 1, 1'b0);

    for (int i = 0; i < 300; i++) begin
      int s;
      if ($urandom_range(14, 0) == 0) begin
        both_strobes(16'($urandom));
      end else begin
        s = ($urandom_range(9, 0) < 7) ? $urandom_range(3, 0)
                                       : $urandom_range(12, 0);
        run_txn(1'($urandom), 16'($urandom), $urandom, $urandom, s,
                $urandom_range(4, 0), $urandom_range(4, 0) == 0);
      end
      repeat ($urandom_range(2, 0)) cyc();
    end

    cyc();
    cyc();
    chk("req_queue_empty", req_q.size(), 0);
    chk("cpl_queue_empty", cpl_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
